// File: rtl/wb_pkg.sv
// Shared widths, PPP encodings and the PPP-to-byte-mask decode for the writeback stage.
// Buses are [0:N-1]: bit 0 is the MSB and mask bit k enables byte k = bits [8k:8k+7].
package wb_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NBYTE  = 8;

    localparam logic [0:2] PPP_A = 3'b000;
    localparam logic [0:2] PPP_U = 3'b001;
    localparam logic [0:2] PPP_D = 3'b010;
    localparam logic [0:2] PPP_E = 3'b011;
    localparam logic [0:2] PPP_O = 3'b100;

    function automatic logic [0:NBYTE-1] ppp_to_mask(input logic [0:2] ppp);
        case (ppp)
            PPP_A:   return 8'b1111_1111;
            PPP_U:   return 8'b1111_0000;
            PPP_D:   return 8'b0000_1111;
            PPP_E:   return 8'b1010_1010;
            PPP_O:   return 8'b0101_0101;
            default: return 8'b0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/regfile_32x64_be.sv
// 32 x 64-bit register file: one byte-enabled write port, two asynchronous read ports,
// synchronous clear. R0 ignores writes and always reads as zero.
module regfile_32x64_be
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [0:REG_AW-1] waddr,
    input  logic [0:NBYTE-1]  wbe,
    input  logic [0:DATA_W-1] wdata,
    input  logic [0:REG_AW-1] raddr_a,
    input  logic [0:REG_AW-1] raddr_b,
    output logic [0:DATA_W-1] rdata_a,
    output logic [0:DATA_W-1] rdata_b
);

    logic [0:DATA_W-1] mem_q [32];
    logic [0:DATA_W-1] mem_d [32];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (wbe[b]) mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback stage: one-entry pending slot for ALU results, register-file write arbitration
// with load priority, younger-load mask merge, and write-through bypass on both read ports.
module wb_commit_stage
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wren,
    input  logic [0:DATA_W-1] ex_result,
    input  logic [0:REG_AW-1] ex_rD,
    input  logic [0:2]        ex_PPP,
    input  logic              ld_valid,
    input  logic [0:REG_AW-1] ld_rD,
    input  logic [0:2]        ld_PPP,
    input  logic [0:DATA_W-1] ld_data,
    input  logic [0:REG_AW-1] rd_addrA,
    input  logic [0:REG_AW-1] rd_addrB,
    output logic [0:DATA_W-1] rd_dataA,
    output logic [0:DATA_W-1] rd_dataB,
    output logic              fwd_valid,
    output logic [0:REG_AW-1] fwd_rD,
    output logic [0:NBYTE-1]  fwd_mask,
    output logic [0:DATA_W-1] fwd_data
);

    logic              pend_valid_q, pend_valid_d;
    logic [0:REG_AW-1] pend_rd_q, pend_rd_d;
    logic [0:NBYTE-1]  pend_mask_q, pend_mask_d;
    logic [0:DATA_W-1] pend_data_q, pend_data_d;

    logic [0:NBYTE-1]  ld_mask, ex_mask;
    logic              pend_commit, accept, ld_wr, pend_wr;
    logic              rf_we;
    logic [0:REG_AW-1] rf_waddr;
    logic [0:NBYTE-1]  rf_wbe;
    logic [0:DATA_W-1] rf_wdata, rf_rdata_a, rf_rdata_b;

    assign ld_mask     = ppp_to_mask(ld_PPP);
    assign ex_mask     = ex_wren ? ppp_to_mask(ex_PPP) : '0;
    assign pend_commit = pend_valid_q & ~ld_valid;
    assign ex_ready    = ~reset & (~pend_valid_q | ~ld_valid);
    assign accept      = ex_valid & ex_ready;
    // Nothing commits at an edge where reset is high, so bypass must not show it either.
    assign ld_wr       = ld_valid & ~reset;
    assign pend_wr     = pend_commit & ~reset;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wbe   = '0;
        rf_wdata = '0;
        if (ld_valid) begin
            rf_we    = 1'b1;
            rf_waddr = ld_rD;
            rf_wbe   = ld_mask;
            rf_wdata = ld_data;
        end else if (pend_valid_q) begin
            rf_we    = 1'b1;
            rf_waddr = pend_rd_q;
            rf_wbe   = pend_mask_q;
            rf_wdata = pend_data_q;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        pend_mask_d  = pend_mask_q;
        pend_data_d  = pend_data_q;
        if (pend_commit) begin
            pend_valid_d = 1'b0;
        end else if (pend_valid_q && (pend_rd_q == ld_rD)) begin
            pend_mask_d = pend_mask_q & ~ld_mask;
        end
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_rd_d    = ex_rD;
            pend_mask_d  = ex_mask;
            pend_data_d  = ex_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            pend_mask_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            pend_mask_q  <= pend_mask_d;
            pend_data_q  <= pend_data_d;
        end
    end

    regfile_32x64_be u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wbe     (rf_wbe),
        .wdata   (rf_wdata),
        .raddr_a (rd_addrA),
        .raddr_b (rd_addrB),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    function automatic logic [0:DATA_W-1] bypass(input logic [0:REG_AW-1] addr,
                                                  input logic [0:DATA_W-1] base);
        logic [0:DATA_W-1] res;
        res = base;
        for (int b = 0; b < NBYTE; b++) begin
            if (pend_wr && (pend_rd_q == addr) && pend_mask_q[b]) begin
                res[8*b +: 8] = pend_data_q[8*b +: 8];
            end
            if (ld_wr && (ld_rD == addr) && ld_mask[b]) begin
                res[8*b +: 8] = ld_data[8*b +: 8];
            end
        end
        if (addr == '0) res = '0;
        return res;
    endfunction

    assign rd_dataA  = bypass(rd_addrA, rf_rdata_a);
    assign rd_dataB  = bypass(rd_addrB, rf_rdata_b);

    assign fwd_valid = pend_valid_q;
    assign fwd_rD    = pend_rd_q;
    assign fwd_mask  = pend_valid_q ? pend_mask_q : '0;
    assign fwd_data  = pend_data_q;

endmodule
